// File: rtl/ex_mdu_seq_pkg.sv
// ex_mdu_seq_pkg: shared types, widths and op decoding for the RV32M multiply/divide sequencer.
package ex_mdu_seq_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CNT_W_DEF = 6;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} op_t;
  // {rs1 signed, rs2 signed}; MUL low half is sign-agnostic so it runs unsigned
  function automatic logic [1:0] op_signs(op_t op);
    return {op == MULH || op == MULHSU || op == DIV || op == REM, op == MULH || op == DIV || op == REM};
  endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration on unsigned magnitudes.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nx,
  output logic [W-1:0] quo_nx
);
  logic [W:0] sh, diff;
  always_comb begin
    sh = {rem, quo[W-1]};
    diff = sh - {1'b0, dvs};
    rem_nx = diff[W] ? sh[W-1:0] : diff[W-1:0];
    quo_nx = {quo[W-2:0], !diff[W]};
  end
endmodule

// File: rtl/ex_mdu_seq.sv
// ex_mdu_seq: RV32M multiply/divide sequencer beside EX, iterating one shift/add-sub step per cycle.
// Define MDU_FAST_MUL_EN to compute MUL* in a single cycle with a hardware multiplier.
module ex_mdu_seq
  import ex_mdu_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [4:0]      waddr_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic            we,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_step, mag;
  logic [XLEN-1:0] dvs, ma, mb, rem_nx, quo_nx, spec_val, fast_res, res;
  logic [XLEN:0] mul_sum;
  logic [2:0] op_r;
  logic [4:0] rd_r;
  logic neg_r, neg, sa, sb, div0, ovf, fast, last;
`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] prod;
`endif
  mdu_div_step #(.W(XLEN)) u_step (
    .rem(acc[2*XLEN-1:XLEN]),
    .quo(acc[XLEN-1:0]),
    .dvs(dvs),
    .rem_nx(rem_nx),
    .quo_nx(quo_nx)
  );
  always_comb begin
    {sa, sb} = op_signs(op_t'(op)) & {data1[XLEN-1], data2[XLEN-1]};
    ma = sa ? -data1 : data1;
    mb = sb ? -data2 : data2;
    neg = (op[2] && op[1]) ? sa : sa ^ sb;
    div0 = op[2] && data2 == '0;
    ovf = op[2] && !op[0] && data1 == MIN && data2 == '1;
    spec_val = div0 ? (op[1] ? data1 : '1) : (op[1] ? '0 : MIN);
`ifdef MDU_FAST_MUL_EN
    fast = !op[2];
    prod = $signed({sa, data1}) * $signed({sb, data2});
    fast_res = op == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`else
    fast = 1'b0;
    fast_res = '0;
`endif
    // acc holds {hi, multiplier} for MUL*, {remainder, dividend/quotient} for DIV*/REM*
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    acc_step = op_r[2] ? {rem_nx, quo_nx} : {mul_sum, acc[XLEN-1:1]};
    mag = op_r[2] ? {{XLEN{1'b0}}, op_r[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0]} : acc_step;
    mag = neg_r ? -mag : mag;
    res = state == IDLE ? (fast ? fast_res : spec_val)
        : (op_r[2] || op_r == MUL) ? mag[XLEN-1:0] : mag[2*XLEN-1:XLEN];
    last = cnt == CNT_W'(XLEN-1);
    state_nx = state == IDLE ? (start ? ((div0 || ovf || fast) ? DONE : CALC) : IDLE)
             : state == CALC ? (last ? DONE : CALC) : IDLE;
    if (flush) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      dvs <= '0;
      op_r <= '0;
      rd_r <= '0;
      neg_r <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (rdy) begin
      state <= state_nx;
      if (state == IDLE && start) begin
        op_r <= op;
        rd_r <= waddr_in;
        neg_r <= neg;
        acc <= {{XLEN{1'b0}}, ma};
        dvs <= mb;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      // result is finalised on the edge entering DONE so it is registered while done is high
      if (state_nx == DONE && state != DONE) begin
        waddr <= state == IDLE ? waddr_in : rd_r;
        wdata <= res;
      end
    end
  end
  assign stall_req = state == CALC || (state == IDLE && start);
  assign done = state == DONE;
  assign we = done;
endmodule

// File: tb/tb_ex_mdu_seq.sv
// tb_ex_mdu_seq: randomized and directed checks of ex_mdu_seq against a plain-arithmetic RV32M model.
module tb_ex_mdu_seq;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] data1 = '0, data2 = '0;
  logic [4:0] waddr_in = '0;
  logic stall_req, done, we;
  logic [4:0] waddr;
  logic [31:0] wdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ex_mdu_seq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .start(start), .op(op), .data1(data1), .data2(data2),
    .waddr_in(waddr_in), .flush(flush), .stall_req(stall_req), .done(done), .we(we),
    .waddr(waddr), .wdata(wdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0] p;
    p = (o == 3'd1) ? sa * sb : (o == 3'd2) ? sa * longint'(ub) : ua * ub;
    if (!o[2]) return o == 3'd0 ? p[31:0] : p[63:32];
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == MIN && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : MIN;
    if (o[0]) return o[1] ? a % b : a / b;
    return o[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input bit poke);
    logic [31:0] exp;
    int lat, want;
    exp = ref_mdu(o, a, b);
    want = (o[2] && (b == 0 || (!o[0] && a == MIN && b == 32'hFFFF_FFFF))) ? 1 : 33 + (hold > 0 ? 5 : 0);
    @(negedge clk);
    op = o; data1 = a; data2 = b; waddr_in = rd; start = 1'b1;
    #1 check("stall_issue", 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0; data1 = $urandom; data2 = $urandom; waddr_in = 5'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      if (poke && lat == 5) begin start = 1'b1; op = ~o; end
      if (poke && lat == 6) start = 1'b0;
      if (hold > 0 && lat == hold) rdy = 1'b0;
      if (hold > 0 && lat == hold + 5) rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(want));
    check("we", 32'(we), 32'd1);
    check("waddr", 32'(waddr), 32'(rd));
    check($sformatf("wdata op%0d %h,%h", o, a, b), wdata, exp);
    @(negedge clk);
    check("done_fall", 32'(done), 32'd0);
    check("stall_idle", 32'(stall_req), 32'd0);
    check("wdata_hold", wdata, exp);
  endtask
  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    int n;
    #1;
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0, 0);
    run_op(3'd5, 32'd100, 32'd0, 5'd4, 0, 0);
    run_op(3'd7, 32'd100, 32'd0, 5'd5, 0, 0);
    run_op(3'd4, MIN, 32'hFFFF_FFFF, 5'd6, 0, 0);
    run_op(3'd6, MIN, 32'hFFFF_FFFF, 5'd7, 0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd10, 0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 0, 0);
    run_op(3'd1, MIN, MIN, 5'd12, 0, 1);
    run_op(3'd7, 32'd1000, 32'd7, 5'd13, 10, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, 0);
    // reset in the middle of an iterative op
    @(negedge clk);
    op = 3'd0; data1 = 32'd3; data2 = 32'd5; waddr_in = 5'd14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_stall", 32'(stall_req), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_we", 32'(we), 32'd0);
    check("arst_waddr", 32'(waddr), 32'd0);
    check("arst_wdata", wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd5, 32'd12345, 32'd67, 5'd15, 0, 0);
    // flush at iteration 10, then an immediate new op
    @(negedge clk);
    op = 3'd0; data1 = 32'd5; data2 = 32'd6; waddr_in = 5'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_stall", 32'(stall_req), 32'd0);
    n = 0;
    repeat (3) begin
      if (done) n++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(n), 32'd0);
    run_op(3'd0, 32'd1234, 32'd5678, 5'd17, 0, 0);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      n = $urandom_range(0, 7);
      if (n == 0) b = 32'd0;
      if (n == 1) b = $urandom_range(1, 9);
      if (n == 2) begin a = MIN; b = 32'hFFFF_FFFF; end
      run_op(o, a, b, 5'($urandom), 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
